mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter sitting directly below the CPU core's cache ports: it accepts instruction-fetch requests (icache side) and load/store requests (dcache side) from the core, serialises them onto one synchronous single-port RAM, and returns ready/data-valid handshakes. Stores that hit the VGA frame-buffer window are redirected to the core's VMEM write port instead of RAM. The core's MEM and IF_ID stages stall on the data-valid pulses this block generates.

## Interface
- ADDR_W, 32, byte-address width
- DATA_W, 64, data/RAM word width (8 byte lanes)
- INST_W, 32, instruction width
- VGA_BASE, 32'h2000_0000, base of VGA window (2 MiB, aligned)
- clk  in  1  system clock, single clock domain
- rst  in  1  reset; synchronous, active-high
- icache_addr_i  in  ADDR_W  fetch byte address
- icache_req_valid_i  in  1  fetch request
- icache_ready_o  out  1  arbiter can accept a fetch
- icache_data_valid_o  out  1  one-cycle fetch completion pulse
- icache_data_o  out  INST_W  fetched instruction
- dcache_addr_i  in  ADDR_W  load/store byte address
- dcache_req_valid_i  in  1  data request
- dcache_wen_i  in  1  1 = store, 0 = load
- dcache_wdata_i  in  DATA_W  store data, LSB-aligned
- dcache_wlen_i  in  2  size: 00 byte, 01 half, 10 word, 11 double
- dcache_ready_o  out  1  arbiter can accept a data request
- dcache_data_valid_o  out  1  one-cycle completion pulse (loads and stores)
- dcache_data_o  out  DATA_W  load data, shifted so addressed byte is bit 0
- misalign_o  out  1  one-cycle pulse: accepted data request misaligned for its size
- ram_en_o  out  1  RAM access strobe
- ram_we_o  out  1  RAM write
- ram_addr_o  out  ADDR_W-3  RAM word index (addr[ADDR_W-1:3])
- ram_wmask_o  out  8  byte-lane write enable
- ram_wdata_o  out  DATA_W  lane-positioned write data
- ram_rdata_i  in  DATA_W  RAM read data, valid one cycle after ram_en_o
- vga_waddr_h_o  out  10  pixel column = addr[11:2]
- vga_waddr_v_o  out  9  pixel row = addr[20:12]
- vga_we_o  out  1  VMEM write strobe
- vga_wdata_o  out  24  pixel RGB = wdata[23:0]

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset → IDLE.
- IDLE: icache_ready_o = dcache_ready_o = ~rst; all others 0. Request accepted at a rising edge when req_valid=1 in IDLE. Both valid → dcache wins (strict priority); icache request stays pending, not dropped. Accepted addr/wen/wdata/wlen and source latched; → ACCESS.
- ACCESS: readies 0. VGA hit (store, addr[ADDR_W-1:21] == VGA_BASE[ADDR_W-1:21]): vga_we_o=1, ram_en_o=0. Otherwise ram_en_o=1, ram_we_o=wen, ram_addr_o = addr[ADDR_W-1:3]. → RESP.
- RESP: matching data_valid_o=1 for one cycle; → IDLE.
- Size alignment: low address bits below the access size ignored (aligned down); misalign_o pulses in ACCESS if any were nonzero. off = aligned addr[2:0].
- Store mask: byte 8'b1<<off; half 8'b11<<off; word 8'hF<<off; double 8'hFF. ram_wdata_o = wdata << (8·off).
- Load data: dcache_data_o = ram_rdata_i >> (8·off), zero-filled above; sign extension is the core's job. Loads from VGA window return 0 from RAM access suppressed (ram_en_o=0).
- Fetch: icache_data_o = addr[2] ? ram_rdata_i[63:32] : ram_rdata_i[31:0]; addr[1:0] ignored.
- Store completion: dcache_data_valid_o pulses, dcache_data_o = 0.
- Outside RESP all data outputs 0.

## Timing
- Acceptance edge T → ACCESS in cycle T+1 (RAM/VGA strobe) → RESP in cycle T+2 (data_valid + data) → ready again in cycle T+3. Throughput one request per 3 cycles.
- Outputs in RESP driven combinationally from ram_rdata_i and latched offset; no extra register.
- rst asserted in any state: next edge → IDLE; ram_en_o, ram_we_o, vga_we_o, data_valid outputs gated to 0 combinationally while rst=1; in-flight request discarded, no completion pulse.
- req_valid dropped after acceptance: ignored, access completes.
- Reset values: all outputs 0 (readies 0 while rst=1, 1 the first cycle after).

## Test plan
- Reset: hold rst 3 cycles with both req_valid=1 → no ram_en_o, readies 0; release → both readies 1, dcache accepted first.
- Fetch 0x0000_0104, RAM word 0x1111_2222_3333_4444 → ram_addr_o=0x20 in T+1, icache_data_valid_o with 0x1111_2222 in T+2.
- Byte store 0xAB at 0x1003 → ram_wmask_o=8'h08, ram_wdata_o=0xAB<<24, ram_we_o=1; dcache_data_valid_o pulse T+2.
- Half load at 0x1006, RAM word 0xBEEF_0000_0000_0000 → dcache_data_o=0xBEEF; word load at 0x1002 → misalign_o pulse, data from 0x1000.
- Simultaneous fetch + load in IDLE → load served (valid T+2), fetch accepted T+3, icache_data_valid_o T+5.
- Store 0x00FF_8800 to 0x2000_5008 → vga_we_o=1, h=2, v=5, vga_wdata_o=0xFF8800, ram_en_o=0; rst asserted in ACCESS of a later load → no valid pulse, IDLE next cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises icache fetches and dcache loads/stores onto one single-port RAM, redirecting frame-buffer stores to VMEM
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int INST_W = 32,
  parameter logic [ADDR_W-1:0] VGA_BASE = 32'h2000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] icache_addr_i,
  input  logic              icache_req_valid_i,
  output logic              icache_ready_o,
  output logic              icache_data_valid_o,
  output logic [INST_W-1:0] icache_data_o,
  input  logic [ADDR_W-1:0] dcache_addr_i,
  input  logic              dcache_req_valid_i,
  input  logic              dcache_wen_i,
  input  logic [DATA_W-1:0] dcache_wdata_i,
  input  logic [1:0]        dcache_wlen_i,
  output logic              dcache_ready_o,
  output logic              dcache_data_valid_o,
  output logic [DATA_W-1:0] dcache_data_o,
  output logic              misalign_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-4:0] ram_addr_o,
  output logic [7:0]        ram_wmask_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic [9:0]        vga_waddr_h_o,
  output logic [8:0]        vga_waddr_v_o,
  output logic              vga_we_o,
  output logic [23:0]       vga_wdata_o
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0] wlen_q, wlen_d;
  logic wen_q, wen_d, dsrc_q, dsrc_d;
  logic [2:0] low_mask, off;
  logic [5:0] sh;
  logic [7:0] size_mask;
  logic in_vga, mis, in_access, in_resp, ram_hit;
  // size decode: bits below the access size are dropped to find the lane offset
  always_comb begin
    low_mask = {&wlen_q, wlen_q[1], |wlen_q};
    off = addr_q[2:0] & ~low_mask;
    mis = |(addr_q[2:0] & low_mask);
    sh = {off, 3'b000};
    size_mask = wlen_q == 2'b00 ? 8'h01 : wlen_q == 2'b01 ? 8'h03 : wlen_q == 2'b10 ? 8'h0F : 8'hFF;
    in_vga = dsrc_q & (addr_q[ADDR_W-1:21] == VGA_BASE[ADDR_W-1:21]);
    in_access = (state_q == ACCESS) & ~rst;
    in_resp = (state_q == RESP) & ~rst;
    ram_hit = in_access & ~in_vga;
  end
  // next state and request capture; dcache has strict priority, an unserved fetch just stays pending
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wlen_d = wlen_q;
    wen_d = wen_q;
    dsrc_d = dsrc_q;
    if (state_q == IDLE && (dcache_req_valid_i || icache_req_valid_i)) begin
      state_d = ACCESS;
      dsrc_d = dcache_req_valid_i;
      addr_d = dcache_req_valid_i ? dcache_addr_i : icache_addr_i;
      wen_d = dcache_req_valid_i & dcache_wen_i;
      wdata_d = dcache_req_valid_i ? dcache_wdata_i : '0;
      wlen_d = dcache_req_valid_i ? dcache_wlen_i : 2'b10;
    end else begin
      state_d = state_q == ACCESS ? RESP : IDLE;
    end
  end
  // state and latched request; reset discards any in-flight access
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      wlen_q <= '0;
      wen_q <= 1'b0;
      dsrc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wlen_q <= wlen_d;
      wen_q <= wen_d;
      dsrc_q <= dsrc_d;
    end
  end
  // handshake, RAM/VMEM strobes and response data, all gated by reset and state
  always_comb begin
    icache_ready_o = (state_q == IDLE) & ~rst;
    dcache_ready_o = (state_q == IDLE) & ~rst;
    ram_en_o = ram_hit;
    ram_we_o = ram_hit & wen_q;
    ram_addr_o = ram_hit ? addr_q[ADDR_W-1:3] : '0;
    ram_wmask_o = ram_hit & wen_q ? size_mask << off : 8'h00;
    ram_wdata_o = ram_hit & wen_q ? wdata_q << sh : '0;
    vga_we_o = in_access & in_vga & wen_q;
    vga_waddr_h_o = vga_we_o ? addr_q[11:2] : '0;
    vga_waddr_v_o = vga_we_o ? addr_q[20:12] : '0;
    vga_wdata_o = vga_we_o ? wdata_q[23:0] : '0;
    misalign_o = in_access & dsrc_q & mis;
    dcache_data_valid_o = in_resp & dsrc_q;
    dcache_data_o = dcache_data_valid_o & ~wen_q & ~in_vga ? ram_rdata_i >> sh : '0;
    icache_data_valid_o = in_resp & ~dsrc_q;
    icache_data_o = !icache_data_valid_o ? '0 : addr_q[2] ? ram_rdata_i[2*INST_W-1:INST_W] : ram_rdata_i[INST_W-1:0];
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, alignment, lane steering, VGA redirect and reset
module tb_mem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] icache_addr_i = '0, dcache_addr_i = '0;
  logic icache_req_valid_i = 1'b0, dcache_req_valid_i = 1'b0, dcache_wen_i = 1'b0;
  logic [63:0] dcache_wdata_i = '0, ram_rdata_i = '0;
  logic [1:0] dcache_wlen_i = '0;
  logic icache_ready_o, icache_data_valid_o, dcache_ready_o, dcache_data_valid_o;
  logic misalign_o, ram_en_o, ram_we_o, vga_we_o;
  logic [31:0] icache_data_o;
  logic [63:0] dcache_data_o, ram_wdata_o;
  logic [28:0] ram_addr_o;
  logic [7:0] ram_wmask_o;
  logic [9:0] vga_waddr_h_o;
  logic [8:0] vga_waddr_v_o;
  logic [23:0] vga_wdata_o;
  int n_chk = 0, n_fail = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .icache_addr_i(icache_addr_i), .icache_req_valid_i(icache_req_valid_i),
    .icache_ready_o(icache_ready_o), .icache_data_valid_o(icache_data_valid_o), .icache_data_o(icache_data_o),
    .dcache_addr_i(dcache_addr_i), .dcache_req_valid_i(dcache_req_valid_i), .dcache_wen_i(dcache_wen_i),
    .dcache_wdata_i(dcache_wdata_i), .dcache_wlen_i(dcache_wlen_i), .dcache_ready_o(dcache_ready_o),
    .dcache_data_valid_o(dcache_data_valid_o), .dcache_data_o(dcache_data_o), .misalign_o(misalign_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_wmask_o(ram_wmask_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
    .vga_waddr_h_o(vga_waddr_h_o), .vga_waddr_v_o(vga_waddr_v_o), .vga_we_o(vga_we_o), .vga_wdata_o(vga_wdata_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_d(input logic [31:0] a, input logic we, input logic [63:0] wd, input logic [1:0] wl);
    dcache_addr_i = a;
    dcache_wen_i = we;
    dcache_wdata_i = wd;
    dcache_wlen_i = wl;
    dcache_req_valid_i = 1'b1;
    tick;
    dcache_req_valid_i = 1'b0;
    dcache_wen_i = 1'b0;
  endtask

  task automatic test_reset;
    icache_req_valid_i = 1'b1;
    icache_addr_i = 32'h0000_0100;
    dcache_req_valid_i = 1'b1;
    dcache_addr_i = 32'h0000_1000;
    dcache_wlen_i = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++; if (ram_en_o !== 1'b0) begin n_fail++; $display("FAIL rst_ram_en cyc%0d got %b exp 0", i, ram_en_o); end
      n_chk++; if ({icache_ready_o, dcache_ready_o} !== 2'b00) begin n_fail++; $display("FAIL rst_ready cyc%0d got %b exp 00", i, {icache_ready_o, dcache_ready_o}); end
    end
    tick;
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if ({icache_ready_o, dcache_ready_o} !== 2'b11) begin n_fail++; $display("FAIL rel_ready got %b exp 11", {icache_ready_o, dcache_ready_o}); end
    tick;
    icache_req_valid_i = 1'b0;
    dcache_req_valid_i = 1'b0;
    @(negedge clk);
    n_chk++; if (ram_addr_o !== 29'h200) begin n_fail++; $display("FAIL rel_first_addr got %h exp 200", ram_addr_o); end
    n_chk++; if (icache_ready_o !== 1'b0) begin n_fail++; $display("FAIL rel_busy_ready got %b exp 0", icache_ready_o); end
    tick;
    ram_rdata_i = 64'h0102_0304_0506_0708;
    @(negedge clk);
    n_chk++; if ({dcache_data_valid_o, icache_data_valid_o} !== 2'b10) begin n_fail++; $display("FAIL rel_first_src got %b exp 10", {dcache_data_valid_o, icache_data_valid_o}); end
    n_chk++; if (dcache_data_o !== 64'h0102_0304_0506_0708) begin n_fail++; $display("FAIL rel_dword got %h exp 0102030405060708", dcache_data_o); end
    tick;
  endtask

  task automatic test_fetch;
    icache_addr_i = 32'h0000_0104;
    icache_req_valid_i = 1'b1;
    tick;
    icache_req_valid_i = 1'b0;
    @(negedge clk);
    n_chk++; if ({ram_en_o, ram_we_o} !== 2'b10) begin n_fail++; $display("FAIL fetch_en_we got %b exp 10", {ram_en_o, ram_we_o}); end
    n_chk++; if (ram_addr_o !== 29'h20) begin n_fail++; $display("FAIL fetch_addr got %h exp 20", ram_addr_o); end
    tick;
    ram_rdata_i = 64'h1111_2222_3333_4444;
    @(negedge clk);
    n_chk++; if (icache_data_valid_o !== 1'b1) begin n_fail++; $display("FAIL fetch_valid got %b exp 1", icache_data_valid_o); end
    n_chk++; if (icache_data_o !== 32'h1111_2222) begin n_fail++; $display("FAIL fetch_data got %h exp 11112222", icache_data_o); end
    n_chk++; if ({dcache_data_valid_o, ram_en_o} !== 2'b00) begin n_fail++; $display("FAIL fetch_resp_quiet got %b exp 00", {dcache_data_valid_o, ram_en_o}); end
    tick;
    @(negedge clk);
    n_chk++; if ({icache_ready_o, icache_data_valid_o, icache_data_o} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL fetch_idle got %b/%b/%h exp 1/0/0", icache_ready_o, icache_data_valid_o, icache_data_o); end
  endtask

  task automatic test_stores;
    tick;
    send_d(32'h0000_1003, 1'b1, 64'hAB, 2'b00);
    @(negedge clk);
    n_chk++; if ({ram_en_o, ram_we_o} !== 2'b11) begin n_fail++; $display("FAIL sb_en_we got %b exp 11", {ram_en_o, ram_we_o}); end
    n_chk++; if (ram_wmask_o !== 8'h08) begin n_fail++; $display("FAIL sb_mask got %h exp 08", ram_wmask_o); end
    n_chk++; if (ram_wdata_o !== 64'hAB00_0000) begin n_fail++; $display("FAIL sb_wdata got %h exp ab000000", ram_wdata_o); end
    n_chk++; if (ram_addr_o !== 29'h200) begin n_fail++; $display("FAIL sb_addr got %h exp 200", ram_addr_o); end
    tick;
    ram_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    n_chk++; if ({dcache_data_valid_o, dcache_data_o} !== {1'b1, 64'h0}) begin n_fail++; $display("FAIL sb_resp got %b/%h exp 1/0", dcache_data_valid_o, dcache_data_o); end
    tick;
    send_d(32'h0000_1004, 1'b1, 64'hDEAD_BEEF, 2'b10);
    @(negedge clk);
    n_chk++; if ({ram_wmask_o, ram_wdata_o} !== {8'hF0, 64'hDEAD_BEEF_0000_0000}) begin n_fail++; $display("FAIL sw_lanes got %h/%h exp f0/deadbeef00000000", ram_wmask_o, ram_wdata_o); end
    n_chk++; if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL sw_misalign got %b exp 0", misalign_o); end
    tick;
    tick;
    send_d(32'h0000_100B, 1'b1, 64'h0123_4567_89AB_CDEF, 2'b11);
    @(negedge clk);
    n_chk++; if ({ram_wmask_o, ram_wdata_o} !== {8'hFF, 64'h0123_4567_89AB_CDEF}) begin n_fail++; $display("FAIL sd_lanes got %h/%h exp ff/0123456789abcdef", ram_wmask_o, ram_wdata_o); end
    n_chk++; if ({misalign_o, ram_addr_o} !== {1'b1, 29'h201}) begin n_fail++; $display("FAIL sd_misalign_addr got %b/%h exp 1/201", misalign_o, ram_addr_o); end
    tick;
    tick;
  endtask

  task automatic test_loads;
    send_d(32'h0000_1006, 1'b0, 64'h0, 2'b01);
    @(negedge clk);
    n_chk++; if ({ram_en_o, ram_we_o, ram_wmask_o, misalign_o} !== {2'b10, 8'h00, 1'b0}) begin n_fail++; $display("FAIL lh_access got %b%b/%h/%b exp 10/00/0", ram_en_o, ram_we_o, ram_wmask_o, misalign_o); end
    tick;
    ram_rdata_i = 64'hBEEF_0000_0000_0000;
    @(negedge clk);
    n_chk++; if ({dcache_data_valid_o, dcache_data_o} !== {1'b1, 64'hBEEF}) begin n_fail++; $display("FAIL lh_data got %b/%h exp 1/beef", dcache_data_valid_o, dcache_data_o); end
    tick;
    send_d(32'h0000_1002, 1'b0, 64'h0, 2'b10);
    @(negedge clk);
    n_chk++; if (misalign_o !== 1'b1) begin n_fail++; $display("FAIL lw_misalign got %b exp 1", misalign_o); end
    tick;
    ram_rdata_i = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    n_chk++; if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL lw_misalign_pulse got %b exp 0", misalign_o); end
    n_chk++; if (dcache_data_o !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL lw_data got %h exp 0123456789abcdef", dcache_data_o); end
    tick;
    send_d(32'h0000_1005, 1'b0, 64'h0, 2'b00);
    tick;
    ram_rdata_i = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    n_chk++; if (dcache_data_o !== 64'h0000_0000_0001_2345) begin n_fail++; $display("FAIL lb_data got %h exp 12345", dcache_data_o); end
    tick;
  endtask

  task automatic test_priority;
    icache_addr_i = 32'h0000_010C;
    icache_req_valid_i = 1'b1;
    dcache_addr_i = 32'h0000_1010;
    dcache_wlen_i = 2'b11;
    dcache_req_valid_i = 1'b1;
    tick;
    dcache_req_valid_i = 1'b0;
    @(negedge clk);
    n_chk++; if (ram_addr_o !== 29'h202) begin n_fail++; $display("FAIL pri_d_addr got %h exp 202", ram_addr_o); end
    tick;
    ram_rdata_i = 64'h5555_6666_7777_8888;
    @(negedge clk);
    n_chk++; if ({dcache_data_valid_o, icache_data_valid_o, dcache_data_o} !== {2'b10, 64'h5555_6666_7777_8888}) begin n_fail++; $display("FAIL pri_d_resp got %b%b/%h exp 10/5555666677778888", dcache_data_valid_o, icache_data_valid_o, dcache_data_o); end
    tick;
    @(negedge clk);
    n_chk++; if (icache_ready_o !== 1'b1) begin n_fail++; $display("FAIL pri_ready got %b exp 1", icache_ready_o); end
    tick;
    icache_req_valid_i = 1'b0;
    @(negedge clk);
    n_chk++; if ({ram_en_o, ram_addr_o} !== {1'b1, 29'h21}) begin n_fail++; $display("FAIL pri_i_addr got %b/%h exp 1/21", ram_en_o, ram_addr_o); end
    tick;
    ram_rdata_i = 64'hCAFE_BABE_DEAD_BEEF;
    @(negedge clk);
    n_chk++; if ({icache_data_valid_o, icache_data_o} !== {1'b1, 32'hCAFE_BABE}) begin n_fail++; $display("FAIL pri_i_resp got %b/%h exp 1/cafebabe", icache_data_valid_o, icache_data_o); end
    tick;
  endtask

  task automatic test_vga;
    send_d(32'h2000_5008, 1'b1, 64'h00FF_8800, 2'b10);
    @(negedge clk);
    n_chk++; if ({vga_we_o, ram_en_o, ram_we_o} !== 3'b100) begin n_fail++; $display("FAIL vga_strobes got %b exp 100", {vga_we_o, ram_en_o, ram_we_o}); end
    n_chk++; if ({vga_waddr_h_o, vga_waddr_v_o, vga_wdata_o} !== {10'd2, 9'd5, 24'hFF8800}) begin n_fail++; $display("FAIL vga_pixel got h%0d v%0d %h exp h2 v5 ff8800", vga_waddr_h_o, vga_waddr_v_o, vga_wdata_o); end
    tick;
    @(negedge clk);
    n_chk++; if ({dcache_data_valid_o, vga_we_o} !== 2'b10) begin n_fail++; $display("FAIL vga_resp got %b exp 10", {dcache_data_valid_o, vga_we_o}); end
    tick;
    send_d(32'h2000_0000, 1'b0, 64'h0, 2'b11);
    @(negedge clk);
    n_chk++; if ({ram_en_o, vga_we_o} !== 2'b00) begin n_fail++; $display("FAIL vga_load_strobes got %b exp 00", {ram_en_o, vga_we_o}); end
    tick;
    ram_rdata_i = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    n_chk++; if ({dcache_data_valid_o, dcache_data_o} !== {1'b1, 64'h0}) begin n_fail++; $display("FAIL vga_load_data got %b/%h exp 1/0", dcache_data_valid_o, dcache_data_o); end
    tick;
  endtask

  task automatic test_reset_inflight;
    send_d(32'h0000_1000, 1'b0, 64'h0, 2'b11);
    @(negedge clk);
    n_chk++; if (ram_en_o !== 1'b1) begin n_fail++; $display("FAIL rif_en_before got %b exp 1", ram_en_o); end
    rst = 1'b1;
    #1;
    n_chk++; if (ram_en_o !== 1'b0) begin n_fail++; $display("FAIL rif_en_gated got %b exp 0", ram_en_o); end
    tick;
    rst = 1'b0;
    ram_rdata_i = 64'hAAAA_BBBB_CCCC_DDDD;
    @(negedge clk);
    n_chk++; if ({dcache_data_valid_o, icache_data_valid_o} !== 2'b00) begin n_fail++; $display("FAIL rif_no_valid got %b exp 00", {dcache_data_valid_o, icache_data_valid_o}); end
    n_chk++; if ({dcache_ready_o, icache_ready_o} !== 2'b11) begin n_fail++; $display("FAIL rif_idle got %b exp 11", {dcache_ready_o, icache_ready_o}); end
    tick;
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_stores;
    test_loads;
    test_priority;
    test_vga;
    test_reset_inflight;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
